// File: rtl/dsp_mac_if.sv
// dsp_mac_if: operand/result handshake bundle for dsp_mac_pipe
interface dsp_mac_if #(
  parameter int A_W = 25,
  parameter int B_W = 18,
  parameter int P_W = 48
);
  logic                  in_valid;
  logic                  in_ready;
  logic signed [A_W-1:0] A;
  logic signed [A_W-1:0] D;
  logic signed [B_W-1:0] B;
  logic signed [P_W-1:0] C;
  logic [2:0]            op;
  logic                  acc_clr;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [P_W-1:0] P;
  logic                  ovf;
  modport master (
    output in_valid, A, D, B, C, op, acc_clr, out_ready,
    input  in_ready, out_valid, P, ovf
  );
  modport slave (
    input  in_valid, A, D, B, C, op, acc_clr, out_ready,
    output in_ready, out_valid, P, ovf
  );
endinterface

// File: rtl/dsp_mac_pipe.sv
// dsp_mac_pipe: 3-stage pre-add/multiply/ALU MAC pipeline; define DSP_MAC_SAT_EN for saturation + sticky ovf
module dsp_mac_pipe #(
  parameter int A_W = 25,
  parameter int B_W = 18,
  parameter int P_W = 48
) (
  input logic      clk,
  input logic      rst,
  dsp_mac_if.slave bus
);
`ifdef DSP_MAC_SAT_EN
  localparam int R_W = P_W + 1;
`else
  localparam int R_W = P_W;
`endif
  logic                  stall, adv, fire, acc_op;
  logic                  v1_q, v1_d, clr1_q, clr1_d;
  logic [2:0]            op1_q, op1_d;
  logic signed [A_W-1:0] a1_q, a1_d, d1_q, d1_d;
  logic signed [B_W-1:0] b1_q, b1_d;
  logic signed [P_W-1:0] c1_q, c1_d;
  logic                  v2_q, v2_d, clr2_q, clr2_d;
  logic [2:0]            op2_q, op2_d;
  logic signed [P_W-1:0] m2_q, m2_d, c2_q, c2_d, a2_q, a2_d;
  logic                  v3_q, v3_d;
  logic signed [P_W-1:0] p_q, p_d, acc_q, acc_d;
  logic signed [A_W:0]   pre;
  logic signed [A_W+B_W:0] prod;
  logic signed [R_W-1:0] m_w, c_w, a_w, acc_w, r;
  logic signed [P_W-1:0] res;
`ifdef DSP_MAC_SAT_EN
  logic                  ovf_now, ovf_q, ovf_d;
  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif
  assign stall        = v3_q && !bus.out_ready;
  assign adv          = !stall;
  assign fire         = adv && v2_q;
  assign bus.in_ready = adv;
  assign bus.out_valid = v3_q;
  assign bus.P        = p_q;
  // Stage datapath: capture operands, pre-add and multiply, then ALU into P/ACC; every stage freezes on stall
  always_comb begin
    v1_d   = adv ? bus.in_valid : v1_q;
    a1_d   = adv ? bus.A : a1_q;
    d1_d   = adv ? bus.D : d1_q;
    b1_d   = adv ? bus.B : b1_q;
    c1_d   = adv ? bus.C : c1_q;
    op1_d  = adv ? bus.op : op1_q;
    clr1_d = adv ? bus.acc_clr : clr1_q;
    pre    = op1_q == 3'b001 ? (A_W+1)'(d1_q) + (A_W+1)'(a1_q) :
             op1_q == 3'b010 ? (A_W+1)'(d1_q) - (A_W+1)'(a1_q) : (A_W+1)'(a1_q);
    prod   = (A_W+B_W+1)'(pre) * (A_W+B_W+1)'(b1_q);
    v2_d   = adv ? v1_q : v2_q;
    m2_d   = adv ? P_W'(prod) : m2_q;
    c2_d   = adv ? c1_q : c2_q;
    a2_d   = adv ? P_W'(a1_q) : a2_q;
    op2_d  = adv ? op1_q : op2_q;
    clr2_d = adv ? clr1_q : clr2_q;
    m_w    = R_W'(m2_q);
    c_w    = R_W'(c2_q);
    a_w    = R_W'(a2_q);
    acc_w  = clr2_q ? '0 : R_W'(acc_q);
    r      = op2_q == 3'b011 ? m_w + c_w :
             op2_q == 3'b100 ? c_w - m_w :
             op2_q == 3'b101 ? acc_w + m_w :
             op2_q == 3'b110 ? acc_w + c_w :
             op2_q == 3'b111 ? a_w + c_w : m_w;
`ifdef DSP_MAC_SAT_EN
    ovf_now = r[P_W] != r[P_W-1];
    res     = !ovf_now ? r[P_W-1:0] :
              r[P_W] ? {1'b1, {(P_W-1){1'b0}}} : {1'b0, {(P_W-1){1'b1}}};
    ovf_d   = ovf_q || (fire && ovf_now);
`else
    res     = r;
`endif
    acc_op = op2_q == 3'b101 || op2_q == 3'b110;
    v3_d   = adv ? v2_q : v3_q;
    p_d    = fire ? res : p_q;
    acc_d  = fire && acc_op ? res : fire && clr2_q ? '0 : acc_q;
  end
  // Pipeline registers; reset discards everything in flight immediately
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v1_q   <= 1'b0;
      a1_q   <= '0;
      d1_q   <= '0;
      b1_q   <= '0;
      c1_q   <= '0;
      op1_q  <= '0;
      clr1_q <= 1'b0;
      v2_q   <= 1'b0;
      m2_q   <= '0;
      c2_q   <= '0;
      a2_q   <= '0;
      op2_q  <= '0;
      clr2_q <= 1'b0;
      v3_q   <= 1'b0;
      p_q    <= '0;
      acc_q  <= '0;
`ifdef DSP_MAC_SAT_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      v1_q   <= v1_d;
      a1_q   <= a1_d;
      d1_q   <= d1_d;
      b1_q   <= b1_d;
      c1_q   <= c1_d;
      op1_q  <= op1_d;
      clr1_q <= clr1_d;
      v2_q   <= v2_d;
      m2_q   <= m2_d;
      c2_q   <= c2_d;
      a2_q   <= a2_d;
      op2_q  <= op2_d;
      clr2_q <= clr2_d;
      v3_q   <= v3_d;
      p_q    <= p_d;
      acc_q  <= acc_d;
`ifdef DSP_MAC_SAT_EN
      ovf_q  <= ovf_d;
`endif
    end
endmodule

// File: tb/tb_dsp_mac_pipe.sv
// tb_dsp_mac_pipe: directed and randomized checks of dsp_mac_pipe against an arithmetic reference model
module tb_dsp_mac_pipe;
  localparam int A_W = 25;
  localparam int B_W = 18;
  localparam int P_W = 48;
  localparam longint MAXV = (64'sd1 <<< (P_W-1)) - 64'sd1;
  localparam longint MINV = -(64'sd1 <<< (P_W-1));
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic signed [P_W-1:0] got_q[$];
  logic signed [P_W-1:0] exp_q[$];
  int got_t[$];
  int acc_t[$];
  longint macc = 0;
  logic movf = 1'b0;

  dsp_mac_if #(.A_W(A_W), .B_W(B_W), .P_W(P_W)) bus();
  dsp_mac_pipe #(.A_W(A_W), .B_W(B_W), .P_W(P_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic signed [P_W-1:0] model(input logic [2:0] op, input logic signed [A_W-1:0] ai,
      input logic signed [A_W-1:0] di, input logic signed [B_W-1:0] bi, input logic signed [P_W-1:0] ci,
      input logic clr);
    longint a = ai;
    longint d = di;
    longint b = bi;
    longint c = ci;
    longint base = clr ? 64'sd0 : macc;
    longint m = ((op == 3'd1) ? d + a : (op == 3'd2) ? d - a : a) * b;
    longint r;
    logic signed [P_W-1:0] res;
    case (op)
      3'd3: r = m + c;
      3'd4: r = c - m;
      3'd5: r = base + m;
      3'd6: r = base + c;
      3'd7: r = a + c;
      default: r = m;
    endcase
`ifdef DSP_MAC_SAT_EN
    if (r > MAXV) begin r = MAXV; movf = 1'b1; end
    else if (r < MINV) begin r = MINV; movf = 1'b1; end
`endif
    res = r[P_W-1:0];
    if (op == 3'd5 || op == 3'd6) macc = res;
    else if (clr) macc = 0;
    return res;
  endfunction

  always @(negedge clk)
    if (!rst) begin
      if (bus.in_valid && bus.in_ready) begin
        acc_t.push_back(cyc);
        exp_q.push_back(model(bus.op, bus.A, bus.D, bus.B, bus.C, bus.acc_clr));
      end
      if (bus.out_valid && bus.out_ready) begin
        got_q.push_back(bus.P);
        got_t.push_back(cyc);
      end
    end

  task automatic clear_q();
    got_q.delete();
    exp_q.delete();
    got_t.delete();
    acc_t.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input longint a, input longint d, input longint b,
      input longint c, input logic clr);
    bit ok = 0;
    bus.op = op;
    bus.A = A_W'(a);
    bus.D = A_W'(d);
    bus.B = B_W'(b);
    bus.C = P_W'(c);
    bus.acc_clr = clr;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.acc_clr = 1'b0;
    if (!ok) begin
      tests++; fails++;
      $display("FAIL send_timeout: operand set not accepted within 50 cycles");
    end
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    macc = 0;
    movf = 1'b0;
    clear_q();
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %0b exp 0", bus.out_valid); end
    tests++; if (bus.P !== '0) begin fails++; $display("FAIL reset_p got %0d exp 0", bus.P); end
    tests++; if (bus.ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf got %0b exp 0", bus.ovf); end
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %0b exp 1", bus.in_ready); end
  endtask

  task automatic test_single();
    clear_q();
    bus.out_ready = 1'b1;
    send(3'd0, -3, 0, 7, 0, 1'b0);
    tick(6);
    tests++;
    if (got_q.size() != 1) begin fails++; $display("FAIL single_count got %0d exp 1", got_q.size()); end
    else begin
      tests++; if (got_q[0] !== -48'sd21) begin fails++; $display("FAIL single_p got %0d exp -21", got_q[0]); end
      tests++; if (got_t[0] - acc_t[0] != 3) begin fails++; $display("FAIL single_latency got %0d exp 3", got_t[0] - acc_t[0]); end
    end
  endtask

  task automatic test_mac_burst();
    longint ev[4] = '{10, 30, 60, 100};
    clear_q();
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) send(3'd5, i, 0, 10, 0, i == 1);
    tick(6);
    tests++;
    if (got_q.size() != 4) begin fails++; $display("FAIL mac_count got %0d exp 4", got_q.size()); end
    else
      for (int i = 0; i < 4; i++) begin
        tests++; if (got_q[i] !== P_W'(ev[i])) begin fails++; $display("FAIL mac_p[%0d] got %0d exp %0d", i, got_q[i], ev[i]); end
        tests++; if (got_t[i] != got_t[0] + i) begin fails++; $display("FAIL mac_cycle[%0d] got %0d exp %0d", i, got_t[i], got_t[0] + i); end
      end
  endtask

  task automatic test_stall();
    clear_q();
    bus.out_ready = 1'b1;
    fork
      for (int i = 0; i < 6; i++) send(3'd1, 2, 5, 3, 0, 1'b0);
      begin
        tick(4);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL stall_in_ready[%0d] got %0b exp 0", k, bus.in_ready); end
          tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL stall_out_valid[%0d] got %0b exp 1", k, bus.out_valid); end
          tests++; if (bus.P !== 48'sd21) begin fails++; $display("FAIL stall_p[%0d] got %0d exp 21", k, bus.P); end
          @(posedge clk);
          #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    tick(10);
    tests++;
    if (got_q.size() != 6) begin fails++; $display("FAIL stall_count got %0d exp 6", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      tests++; if (got_q[i] !== 48'sd21) begin fails++; $display("FAIL stall_result[%0d] got %0d exp 21", i, got_q[i]); end
    end
  endtask

  task automatic test_overflow();
    logic signed [P_W-1:0] e2;
    logic eo;
`ifdef DSP_MAC_SAT_EN
    e2 = P_W'(MAXV);
    eo = 1'b1;
`else
    e2 = -48'sd2;
    eo = 1'b0;
`endif
    clear_q();
    bus.out_ready = 1'b1;
    send(3'd6, 0, 0, 0, MAXV, 1'b1);
    send(3'd6, 0, 0, 0, MAXV, 1'b0);
    tick(6);
    tests++;
    if (got_q.size() != 2) begin fails++; $display("FAIL ovf_count got %0d exp 2", got_q.size()); end
    else begin
      tests++; if (got_q[0] !== P_W'(MAXV)) begin fails++; $display("FAIL ovf_first got %0d exp %0d", got_q[0], MAXV); end
      tests++; if (got_q[1] !== e2) begin fails++; $display("FAIL ovf_second got %0d exp %0d", got_q[1], e2); end
    end
    tests++; if (bus.ovf !== eo) begin fails++; $display("FAIL ovf_flag got %0b exp %0b", bus.ovf, eo); end
  endtask

  task automatic test_reset_inflight();
    int seen = 0;
    clear_q();
    bus.out_ready = 1'b0;
    send(3'd5, 7, 0, 7, 0, 1'b1);
    send(3'd5, 7, 0, 7, 0, 1'b0);
    send(3'd5, 7, 0, 7, 0, 1'b0);
    rst = 1'b1;
    #1;
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rst_async_out_valid got %0b exp 0", bus.out_valid); end
    tests++; if (bus.P !== '0) begin fails++; $display("FAIL rst_async_p got %0d exp 0", bus.P); end
    tests++; if (bus.ovf !== 1'b0) begin fails++; $display("FAIL rst_async_ovf got %0b exp 0", bus.ovf); end
    tick(1);
    rst = 1'b0;
    macc = 0;
    movf = 1'b0;
    clear_q();
    bus.out_ready = 1'b1;
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready got %0b exp 1", bus.in_ready); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
      @(posedge clk);
      #1;
    end
    tests++; if (seen != 0) begin fails++; $display("FAIL rst_ghost_outputs got %0d exp 0", seen); end
    send(3'd5, 2, 0, 2, 0, 1'b0);
    tick(6);
    tests++;
    if (got_q.size() != 1) begin fails++; $display("FAIL rst_mac_count got %0d exp 1", got_q.size()); end
    else begin
      tests++; if (got_q[0] !== 48'sd4) begin fails++; $display("FAIL rst_mac_p got %0d exp 4", got_q[0]); end
    end
  endtask

  task automatic test_random();
    int n;
    clear_q();
    for (int i = 0; i < 400; i++) begin
      bus.in_valid = $urandom_range(0, 9) < 7;
      bus.op = 3'($urandom);
      bus.A = A_W'($urandom);
      bus.D = A_W'($urandom);
      bus.B = B_W'($urandom);
      bus.C = ($urandom_range(0, 1) == 0) ? P_W'({$urandom, $urandom}) : P_W'($urandom_range(0, 1000)) - 48'sd500;
      bus.acc_clr = $urandom_range(0, 7) == 0;
      bus.out_ready = $urandom_range(0, 3) != 0;
      tick(1);
    end
    bus.in_valid = 1'b0;
    bus.acc_clr = 1'b0;
    bus.out_ready = 1'b1;
    tick(8);
    tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL rand_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    n = got_q.size() < exp_q.size() ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL rand_p[%0d] got %0d exp %0d", i, got_q[i], exp_q[i]); end
    end
    tests++; if (bus.ovf !== movf) begin fails++; $display("FAIL rand_ovf got %0b exp %0b", bus.ovf, movf); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.A = '0;
    bus.D = '0;
    bus.B = '0;
    bus.C = '0;
    bus.op = '0;
    bus.acc_clr = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_single();
    test_mac_burst();
    test_stall();
    test_overflow();
    test_reset_inflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dsp_mac_pipe.md
DSP_MAC_PIPE -- requirements
Module: dsp_mac_pipe

Interface
REQ-001 Parameter A_W, default 25, signed width of operands A and D.
REQ-002 Parameter B_W, default 18, signed width of operand B.
REQ-003 Parameter P_W, default 48, signed width of C, accumulator and P; legal only if A_W+1+B_W <= P_W.
REQ-004 Port clk, input, 1, sole clock; all state updates on rising edge.
REQ-005 Port rst, input, 1, asynchronous active-high reset.
REQ-006 Port in_valid, input, 1, operand set valid.
REQ-007 Port in_ready, output, 1, block accepts operand set this cycle.
REQ-008 Ports A, D, input, A_W each; B, input, B_W; C, input, P_W; all two's complement.
REQ-009 Port op, input, 3, operation select (REQ-015).
REQ-010 Port acc_clr, input, 1, qualified by in_valid; zero accumulator before this op.
REQ-011 Port out_valid, output, 1, P holds a result.
REQ-012 Port out_ready, input, 1, downstream accepts P.
REQ-013 Port P, output, P_W, result; port ovf, output, 1, sticky overflow flag.

Function
REQ-014 Three-stage pipeline: S1 registers operands/op, S2 registers pre-adder output times B, S3 registers ALU result into P; latency exactly 3 cycles from accept to out_valid.
REQ-015 op encoding, M = pre-add times B: 000 P=A*B; 001 P=(D+A)*B; 010 P=(D-A)*B; 011 P=A*B+C; 100 P=C-A*B; 101 P=ACC+A*B (MAC); 110 P=ACC+C; 111 P=A+C (A sign-extended, no multiply).
REQ-016 Pre-adder width A_W+1 bits, no wrap; product sign-extended to P_W before ALU.
REQ-017 ACC is internal P_W register, updated in S3 only by ops 101 and 110 with the result written to P.
REQ-018 acc_clr=1 on an accepted op makes S3 use ACC=0 for that op; with a non-accumulating op ACC becomes 0 after it completes.
REQ-019 Back-to-back MACs accepted on consecutive cycles each see ACC including all earlier accepted MACs (S3 forwarding, no bubbles).
REQ-020 Accept when in_valid && in_ready; in_ready = !(out_valid && !out_ready).
REQ-021 Stall: while out_valid && !out_ready all stages, P, ACC hold; P stable until accepted.
REQ-022 Bubbles propagate as invalid stage entries; out_valid drops the cycle after P is taken with no valid entry behind it.
REQ-023 Inputs ignored when not accepted; acc_clr without accept has no effect.

Reset
REQ-024 rst asserted: stage valids, out_valid, P, ACC, ovf go to 0 immediately, asynchronously.
REQ-025 In-flight ops at reset are discarded, never emitted; in_ready=1 from first cycle after rst deasserts.

Configuration
REQ-026 Macro DSP_MAC_SAT_EN defined: S3 results outside signed P_W range clamp to max/min, ACC stores clamped value, ovf sets and stays set until rst.
REQ-027 DSP_MAC_SAT_EN undefined: results wrap modulo 2^P_W, ovf tied to 0, no saturation logic present.

Verification
REQ-028 op=000, A=-3, B=7, out_ready=1 -> P=-21 with out_valid exactly 3 cycles after accept.
REQ-029 Four consecutive op=101, acc_clr=1 on first, A=1..4, B=10 -> P sequence 10,30,60,100 on consecutive cycles.
REQ-030 Stream of 6 op=001 (D=5, A=2, B=3), out_ready low cycles 4-6 -> in_ready low while stalled, P=21 held, no result lost or duplicated.
REQ-031 op=110, C=2^(P_W-1)-1 twice after acc_clr -> SAT_EN: P=2^(P_W-1)-1, ovf=1; no SAT_EN: P wraps to -2, ovf=0.
REQ-032 rst pulsed with 3 ops in flight -> no out_valid afterwards, P=0, ACC=0, next MAC with A=2, B=2 gives 4.
